// File: rtl/simplex8_pkg.sv
// Shared definitions for the simplex8 fetch path: address width and type.
package simplex8_pkg;

  localparam int unsigned ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Overflowing pushes and underflowing pops are dropped
// so stored entries are never corrupted; the caller flags the error.
module return_stack
  import simplex8_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1),
  localparam int unsigned IdxW = $clog2(STACK_DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  addr_t           push_data_i,
  output addr_t           top_o,
  output logic [CntW-1:0] count_o
);

  addr_t           mem_q [STACK_DEPTH];
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] top_idx;
  logic [IdxW-1:0] wr_idx;
  logic            full, empty;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(STACK_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;
  assign top_idx = count_q - CntW'(1);
  assign wr_idx  = count_q[IdxW-1:0];

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry contents are not reset; a zero count makes them unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

  assign top_o   = empty ? '0 : mem_q[top_idx[IdxW-1:0]];
  assign count_o = count_q;

endmodule

// File: rtl/program_counter.sv
// Fetch-address register with fixed-priority next-PC selection
// (return > call > jump > increment) and a bounded return stack.
module program_counter
  import simplex8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00,
  parameter int unsigned       STACK_DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              DOJUMP,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  input  logic              CALL,
  input  logic              RET,
  output logic [ADDR_W-1:0] PC,
  output logic              STACK_EMPTY,
  output logic              STACK_FULL,
  output logic              STACK_ERR
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

  addr_t           pc_q, pc_d, pc_inc;
  logic            err_q, err_d;
  logic            push, pop;
  addr_t           stk_top;
  logic [CntW-1:0] stk_count;

  assign pc_inc      = pc_q + addr_t'(1);
  assign STACK_EMPTY = (stk_count == '0);
  assign STACK_FULL  = (stk_count == CntW'(STACK_DEPTH));

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (EN) begin
      if (RET) begin
        // Underflow falls through to a plain increment.
        if (!STACK_EMPTY) begin
          pc_d = stk_top;
          pop  = 1'b1;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (CALL) begin
        pc_d = addr_t'(JUMP_ADDR);
        if (!STACK_FULL) begin
          push = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (DOJUMP) begin
        pc_d = addr_t'(JUMP_ADDR);
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q  <= addr_t'(RESET_VECTOR);
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  return_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .push_i     (push),
    .pop_i      (pop),
    .push_data_i(pc_inc),
    .top_o      (stk_top),
    .count_o    (stk_count)
  );

  assign PC        = pc_q;
  assign STACK_ERR = err_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: each step queues its expected state,
// which is popped and checked one clock edge later.
module tb_program_counter;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, dojump, call, ret;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic       stack_empty, stack_full, stack_err;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  program_counter #(
    .RESET_VECTOR(8'h10),
    .STACK_DEPTH (4)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .EN         (en),
    .DOJUMP     (dojump),
    .JUMP_ADDR  (jump_addr),
    .CALL       (call),
    .RET        (ret),
    .PC         (pc),
    .STACK_EMPTY(stack_empty),
    .STACK_FULL (stack_full),
    .STACK_ERR  (stack_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then
  // sample #1 after the rising edge and compare.
  task automatic step(input string tag, input logic r, input logic e, input logic j,
                      input logic c, input logic rt, input logic [7:0] addr,
                      input logic [7:0] x_pc, input logic x_empty, input logic x_full,
                      input logic x_err);
    exp_t x;
    exp_t got;
    rst_n     = r;
    en        = e;
    dojump    = j;
    call      = c;
    ret       = rt;
    jump_addr = addr;
    x.tag = tag; x.pc = x_pc; x.empty = x_empty; x.full = x_full; x.err = x_err;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      got = exp_q.pop_front();
      check({got.tag, ".pc"},    pc,                 got.pc);
      check({got.tag, ".empty"}, {7'd0, stack_empty}, {7'd0, got.empty});
      check({got.tag, ".full"},  {7'd0, stack_full},  {7'd0, got.full});
      check({got.tag, ".err"},   {7'd0, stack_err},   {7'd0, got.err});
    end
  endtask

  initial begin
    //    tag          rst en jmp cal ret addr   pc     emp ful err
    step("reset",      0,  0,  0,  0,  0, 8'h00, 8'h10, 1,  0,  0);
    step("stall0",     1,  0,  0,  0,  0, 8'h00, 8'h10, 1,  0,  0);
    step("inc1",       1,  1,  0,  0,  0, 8'h00, 8'h11, 1,  0,  0);
    step("inc2",       1,  1,  0,  0,  0, 8'h00, 8'h12, 1,  0,  0);
    step("inc3",       1,  1,  0,  0,  0, 8'h00, 8'h13, 1,  0,  0);
    step("jmp_fe",     1,  1,  1,  0,  0, 8'hFE, 8'hFE, 1,  0,  0);
    step("wrap_ff",    1,  1,  0,  0,  0, 8'h00, 8'hFF, 1,  0,  0);
    step("wrap_00",    1,  1,  0,  0,  0, 8'h00, 8'h00, 1,  0,  0);
    step("jmp_20",     1,  1,  1,  0,  0, 8'h20, 8'h20, 1,  0,  0);
    step("call_80",    1,  1,  0,  1,  0, 8'h80, 8'h80, 0,  0,  0);
    step("sub_81",     1,  1,  0,  0,  0, 8'h00, 8'h81, 0,  0,  0);
    step("sub_82",     1,  1,  0,  0,  0, 8'h00, 8'h82, 0,  0,  0);
    step("ret_21",     1,  1,  0,  0,  1, 8'h00, 8'h21, 1,  0,  0);
    // Fill the stack: pushes 22, A1, B1, C1; the fifth call overflows.
    step("call1",      1,  1,  0,  1,  0, 8'hA0, 8'hA0, 0,  0,  0);
    step("call2",      1,  1,  0,  1,  0, 8'hB0, 8'hB0, 0,  0,  0);
    step("call3",      1,  1,  0,  1,  0, 8'hC0, 8'hC0, 0,  0,  0);
    step("call4",      1,  1,  0,  1,  0, 8'hD0, 8'hD0, 0,  1,  0);
    step("call5_ovf",  1,  1,  0,  1,  0, 8'hE0, 8'hE0, 0,  1,  1);
    step("ret1",       1,  1,  0,  0,  1, 8'h00, 8'hC1, 0,  0,  1);
    step("ret2",       1,  1,  0,  0,  1, 8'h00, 8'hB1, 0,  0,  1);
    step("ret3",       1,  1,  0,  0,  1, 8'h00, 8'hA1, 0,  0,  1);
    step("ret4",       1,  1,  0,  0,  1, 8'h00, 8'h22, 1,  0,  1);
    step("err_sticky", 1,  1,  0,  0,  0, 8'h00, 8'h23, 1,  0,  1);
    step("reset2",     0,  1,  1,  1,  0, 8'h55, 8'h10, 1,  0,  0);
    step("jmp_05",     1,  1,  1,  0,  0, 8'h05, 8'h05, 1,  0,  0);
    step("ret_unf",    1,  1,  0,  0,  1, 8'h00, 8'h06, 1,  0,  1);
    step("reset3",     0,  1,  0,  0,  0, 8'h00, 8'h10, 1,  0,  0);
    step("jmp_3f",     1,  1,  1,  0,  0, 8'h3F, 8'h3F, 1,  0,  0);
    step("call_70",    1,  1,  0,  1,  0, 8'h70, 8'h70, 0,  0,  0);
    step("cal_ret_jmp",1,  1,  1,  1,  1, 8'h99, 8'h40, 1,  0,  0);
    // A second return must underflow, proving the combined request pushed nothing.
    step("ret_nopush", 1,  1,  0,  0,  1, 8'h00, 8'h41, 1,  0,  1);
    step("stall_jmp",  1,  0,  1,  0,  0, 8'h33, 8'h41, 1,  0,  1);
    step("stall_call", 1,  0,  0,  1,  0, 8'h77, 8'h41, 1,  0,  1);
    step("rst_stall",  0,  0,  0,  0,  0, 8'h00, 8'h10, 1,  0,  0);
    step("hold_en0",   1,  0,  0,  0,  0, 8'h00, 8'h10, 1,  0,  0);
    step("first_inc",  1,  1,  0,  0,  0, 8'h00, 8'h11, 1,  0,  0);
    // Reset mid-call-sequence discards the stacked return address.
    step("call_50",    1,  1,  0,  1,  0, 8'h50, 8'h50, 0,  0,  0);
    step("rst_mid",    0,  1,  0,  0,  0, 8'h00, 8'h10, 1,  0,  0);
    step("ret_after",  1,  1,  0,  0,  1, 8'h00, 8'h11, 1,  0,  1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 8'h00: PC value after reset.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4: return-stack entries, legal range 2..16.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port EN, input, 1 bit: advance enable; low means stall.
REQ-006 The block SHALL have port DOJUMP, input, 1 bit: taken-jump request from the jump-condition stage.
REQ-007 The block SHALL have port JUMP_ADDR, input, 8 bits: target for a jump or call.
REQ-008 The block SHALL have port CALL, input, 1 bit: subroutine call request.
REQ-009 The block SHALL have port RET, input, 1 bit: subroutine return request.
REQ-010 The block SHALL have port PC, output, 8 bits: current fetch address, registered.
REQ-011 The block SHALL have port STACK_EMPTY, output, 1 bit: return stack holds 0 entries.
REQ-012 The block SHALL have port STACK_FULL, output, 1 bit: return stack holds STACK_DEPTH entries.
REQ-013 The block SHALL have port STACK_ERR, output, 1 bit: sticky flag set on overflow or underflow.

Function
REQ-014 With EN=0, PC, stack contents, stack pointer and STACK_ERR SHALL hold, and all requests SHALL be ignored.
REQ-015 With EN=1, the next PC SHALL be chosen by fixed priority: RET > CALL > DOJUMP > increment.
REQ-016 For increment, next PC SHALL be PC+1 modulo 256, so 8'hFF wraps to 8'h00.
REQ-017 For DOJUMP with CALL=0 and RET=0, next PC SHALL be JUMP_ADDR, and the stack SHALL be unchanged.
REQ-018 For CALL with STACK_FULL=0, the block SHALL push PC+1 (mod 256), load JUMP_ADDR into PC, and increment the stack count.
REQ-019 For CALL with STACK_FULL=1, PC SHALL load JUMP_ADDR, no push SHALL occur, stored entries SHALL be unchanged, and STACK_ERR SHALL set.
REQ-020 For RET with STACK_EMPTY=0, PC SHALL load the top entry, and the stack count SHALL decrement.
REQ-021 For RET with STACK_EMPTY=1, PC SHALL increment, and STACK_ERR SHALL set.
REQ-022 For simultaneous CALL and RET, only RET SHALL take effect; no push SHALL occur.
REQ-023 DOJUMP SHALL be ignored whenever CALL or RET is asserted.
REQ-024 PC SHALL update one cycle after the request edge: single-cycle latency, no combinational path from inputs to PC.
REQ-025 STACK_EMPTY and STACK_FULL SHALL be decoded from the registered stack count and SHALL be valid in the same cycle as the count.
REQ-026 Once set, STACK_ERR SHALL remain set until reset.

Reset
REQ-027 When RST_N=0 at a rising CLK edge, the block SHALL set PC=RESET_VECTOR, stack count=0, STACK_EMPTY=1, STACK_FULL=0 and STACK_ERR=0, regardless of EN or any request.
REQ-028 Reset asserted mid-call-sequence SHALL discard all stacked return addresses; entry contents need not be cleared.
REQ-029 The first post-reset PC update SHALL occur on the first edge with RST_N=1 and EN=1.

Structure
REQ-030 The shared package simplex8_pkg SHALL hold ADDR_W=8 and the address typedef; the PC and stack SHALL use it.
REQ-031 The return stack SHALL be a sub-module, return_stack (push, pop, top, count, full, empty), parameterised by STACK_DEPTH.
REQ-032 The next-PC priority mux SHALL reside in program_counter.

Verification
REQ-033 The bench SHALL cover: reset with RESET_VECTOR=8'h10, then 3 cycles with EN=1 -> PC = 10, 11, 12, 13.
REQ-034 The bench SHALL cover: PC=8'hFE, EN=1, no requests, 2 cycles -> PC = FF, then 00.
REQ-035 The bench SHALL cover: PC=8'h20, CALL with JUMP_ADDR=8'h80, then 2 increments, then RET -> PC = 80, 81, 82, then 21, and STACK_EMPTY=1.
REQ-036 The bench SHALL cover: 5 CALLs with STACK_DEPTH=4 -> STACK_FULL after the 4th, STACK_ERR=1 after the 5th, PC = the 5th JUMP_ADDR; then 4 RETs return the 4 pushed addresses in LIFO order.
REQ-037 The bench SHALL cover: RET on an empty stack at PC=8'h05 -> PC=06 and STACK_ERR=1; CALL+RET+DOJUMP together with 1 entry 8'h40 -> PC=40 and no push.
REQ-038 The bench SHALL cover: EN=0 with DOJUMP=1 and JUMP_ADDR=8'h33 -> PC holds; RST_N=0 during EN=0 -> PC=RESET_VECTOR on the next edge.
